des_cbc_feeder: RTL and testbench

Upstream stage for the DES core. Accepts a byte stream and packs every 8 bytes into a 64-bit block, MSB byte first. XORs each block with the CBC chaining value (IV for the first block, then the previous ciphertext) and launches it into the DES core with a one-cycle start pulse. Waits for the core's valid, updates the chaining value, and presents the ciphertext block on a valid/ready output port.

---
 rtl/des_cbc_feeder_if.sv | 28 ++
 rtl/des_cbc_feeder.sv | 148 ++++++++++++++
 tb/tb_des_cbc_feeder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/des_cbc_feeder_if.sv
// Byte-stream / DES-core / ciphertext-stream signal bundle for des_cbc_feeder.
//   in_byte, in_valid, in_ready           : byte input stream
//   des_plain_text, des_start             : launch side of the DES core
//   des_cipher_text, des_dat_valid        : result side of the DES core
//   out_block, out_valid, out_ready       : ciphertext block output stream
// The feeder connects through the slave modport; its environment uses master.
interface des_cbc_feeder_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] des_plain_text;
    logic        des_start;
    logic [63:0] des_cipher_text;
    logic        des_dat_valid;
    logic [63:0] out_block;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_byte, in_valid, des_cipher_text, des_dat_valid, out_ready,
        output in_ready, des_plain_text, des_start, out_block, out_valid
    );

    modport master (
        output in_byte, in_valid, des_cipher_text, des_dat_valid, out_ready,
        input  in_ready, des_plain_text, des_start, out_block, out_valid
    );
endinterface

// File: rtl/des_cbc_feeder.sv
// CBC front end for a DES core: packs 8 bytes MSB-first into a block, XORs it
// with the chaining value, launches the core, captures the ciphertext as the
// new chaining value and offers it on a valid/ready output.
//   clk, rst  : clock, synchronous active-high reset
//   iv,iv_load: chaining-register load (only between blocks, before byte 0)
//   bus       : byte input, DES core launch/result, ciphertext output
//   busy      : block in flight (LAUNCH, WAIT, OUTPUT)
//   err       : sticky DES-core timeout flag
//   blk_cnt   : blocks delivered, wraps
module des_cbc_feeder #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        iv,
    input  logic               iv_load,
    des_cbc_feeder_if.slave    bus,
    output logic               busy,
    output logic               err,
    output logic [CNT_W-1:0]   blk_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        count_q;
    logic [63:0]       shift_q;
    logic [63:0]       chain_q;
    logic [63:0]       plain_q;
    logic              start_q;
    logic [63:0]       out_block_q;
    logic              out_valid_q;
    logic              err_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic [TMR_W-1:0]  timer_q;

    logic              accept;
    logic              last_byte;
    logic              result;
    logic              timeout;
    logic              handshake;
    logic              chain_load;
    logic [63:0]       shift_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_COLLECT;
        else     state_q <= state_d;
    end

    // Next state, handshake decode and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        bus.in_ready = 1'b0;
        accept     = 1'b0;
        last_byte  = 1'b0;
        result     = 1'b0;
        timeout    = 1'b0;
        handshake  = 1'b0;
        chain_load = 1'b0;
        shift_d    = {shift_q[55:0], bus.in_byte};

        case (state_q)
            S_COLLECT: begin
                bus.in_ready = 1'b1;
                accept     = bus.in_valid;
                last_byte  = bus.in_valid && (count_q == 3'd7);
                chain_load = iv_load && (count_q == 3'd0);
                if (last_byte) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                busy    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // A result on the final cycle beats the timeout.
                if (bus.des_dat_valid) begin
                    result  = 1'b1;
                    state_d = S_OUTPUT;
                end else if (timer_q == TMR_LAST) begin
                    timeout = 1'b1;
                    state_d = S_COLLECT;
                end
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                handshake = bus.out_ready;
                if (bus.out_ready) state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 3'd0;
            shift_q     <= 64'd0;
            chain_q     <= 64'd0;
            plain_q     <= 64'd0;
            start_q     <= 1'b0;
            out_block_q <= 64'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            blk_cnt_q   <= '0;
            timer_q     <= '0;
        end else begin
            start_q <= last_byte;
            if (accept) begin
                shift_q <= shift_d;
                count_q <= count_q + 3'd1;   // wraps to 0 after the 8th byte
            end
            if (chain_load) chain_q <= iv;
            if (last_byte)  plain_q <= shift_d ^ chain_q;
            if (state_q == S_LAUNCH) timer_q <= '0;
            else if (state_q == S_WAIT) timer_q <= timer_q + TMR_W'(1);
            if (result) begin
                chain_q     <= bus.des_cipher_text;
                out_block_q <= bus.des_cipher_text;
                out_valid_q <= 1'b1;
            end
            if (timeout) err_q <= 1'b1;
            if (handshake) begin
                out_valid_q <= 1'b0;
                blk_cnt_q   <= blk_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.des_plain_text = plain_q;
    assign bus.des_start      = start_q;
    assign bus.out_block      = out_block_q;
    assign bus.out_valid      = out_valid_q;
    assign err                = err_q;
    assign blk_cnt            = blk_cnt_q;

endmodule

// File: tb/tb_des_cbc_feeder.sv
// Directed bench for des_cbc_feeder with a hand-driven DES core stub.
module tb_des_cbc_feeder;

    localparam int unsigned TO    = 16;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      iv;
    logic             iv_load;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] blk_cnt;

    int checks   = 0;
    int failures = 0;

    des_cbc_feeder_if bus ();

    des_cbc_feeder #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .iv      (iv),
        .iv_load (iv_load),
        .bus     (bus),
        .busy    (busy),
        .err     (err),
        .blk_cnt (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [63:0] blk;

    initial begin
        rst = 1'b1; iv = 64'd0; iv_load = 1'b0;
        bus.in_byte = 8'h00; bus.in_valid = 1'b1;
        bus.des_cipher_text = 64'hDEAD_BEEF_DEAD_BEEF; bus.des_dat_valid = 1'b1;
        bus.out_ready = 1'b0;

        // Reset with noisy inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_start", 64'(bus.des_start), 64'd0);
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.des_dat_valid = 1'b0;
        chk("rst_plain",     bus.des_plain_text, 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_block", bus.out_block, 64'd0);
        chk("rst_err",       64'(err), 64'd0);
        chk("rst_blk_cnt",   64'(blk_cnt), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_busy",      64'(busy), 64'd0);

        // First block: IV load then bytes 00..07
        iv = 64'h0123_4567_89AB_CDEF; iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        chk("b1_start",    64'(bus.des_start), 64'd1);
        chk("b1_plain",    bus.des_plain_text, 64'h0122_4764_8DAE_CBE8);
        chk("b1_in_ready", 64'(bus.in_ready), 64'd0);
        chk("b1_busy",     64'(busy), 64'd1);
        tick();
        chk("b1_start_pulse", 64'(bus.des_start), 64'd0);
        chk("b1_plain_hold",  bus.des_plain_text, 64'h0122_4764_8DAE_CBE8);

        // Core answers with latency 16 from the start pulse
        ticks(14);
        bus.des_cipher_text = 64'hFFFF_0000_FFFF_0000; bus.des_dat_valid = 1'b1;
        tick();
        bus.des_dat_valid = 1'b0;
        chk("b1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("b1_out_block", bus.out_block, 64'hFFFF_0000_FFFF_0000);
        chk("b1_err",       64'(err), 64'd0);

        // Backpressure with bytes on offer
        bus.in_byte = 8'hAA; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_block", bus.out_block, 64'hFFFF_0000_FFFF_0000);
            chk("bp_in_ready",  64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("hs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("hs_blk_cnt",   64'(blk_cnt), 64'd1);
        chk("hs_in_ready",  64'(bus.in_ready), 64'd1);

        // Second block of zeros: plain equals the chained ciphertext
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        chk("b2_start", 64'(bus.des_start), 64'd1);
        chk("b2_plain", bus.des_plain_text, 64'hFFFF_0000_FFFF_0000);

        // Result arrives on the timeout cycle: accepted, no err
        ticks(16);
        chk("pri_pre_valid", 64'(bus.out_valid), 64'd0);
        bus.des_cipher_text = 64'h0F1E_2D3C_4B5A_6978; bus.des_dat_valid = 1'b1;
        tick();
        bus.des_dat_valid = 1'b0;
        chk("pri_out_valid", 64'(bus.out_valid), 64'd1);
        chk("pri_out_block", bus.out_block, 64'h0F1E_2D3C_4B5A_6978);
        chk("pri_err",       64'(err), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pri_blk_cnt", 64'(blk_cnt), 64'd2);

        // iv_load after 3 bytes is ignored
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        iv = 64'd0; iv_load = 1'b1;
        send_byte(8'h44);
        iv_load = 1'b0;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        chk("ivl_start", 64'(bus.des_start), 64'd1);
        chk("ivl_plain", bus.des_plain_text, 64'h1E3C_1E78_1E3C_1EF0);

        // Core never answers: err after 16 waiting cycles
        ticks(16);
        chk("to_err_early", 64'(err), 64'd0);
        chk("to_busy_early", 64'(busy), 64'd1);
        tick();
        chk("to_err",       64'(err), 64'd1);
        chk("to_in_ready",  64'(bus.in_ready), 64'd1);
        chk("to_out_valid", 64'(bus.out_valid), 64'd0);
        chk("to_blk_cnt",   64'(blk_cnt), 64'd2);

        // Chain unchanged by the abandoned block
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        chk("to_chain_plain", bus.des_plain_text, 64'h0F1E_2D3C_4B5A_6978);

        // Reset in WAIT, then a late result
        ticks(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.des_cipher_text = 64'h1234_5678_9ABC_DEF0; bus.des_dat_valid = 1'b1;
        tick();
        bus.des_dat_valid = 1'b0;
        tick();
        chk("late_out_valid", 64'(bus.out_valid), 64'd0);
        chk("late_blk_cnt",   64'(blk_cnt), 64'd0);
        chk("late_err",       64'(err), 64'd0);
        chk("late_in_ready",  64'(bus.in_ready), 64'd1);
        blk = 64'h0001_0203_0405_0607;
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        chk("late_chain_zero", bus.des_plain_text, blk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
